// File: rtl/period_meter.sv
// Measures the rising-to-rising period of a slow asynchronous square wave in
// clk_in cycles, with a timeout indication and a 4-bit rising-edge counter.
module period_meter #(
  parameter int CNT_WIDTH      = 25,
  parameter int TIMEOUT_CYCLES = 25000000
) (
  input  logic                 clk_in,
  input  logic                 rst,
  input  logic                 sig_in,
  output logic [CNT_WIDTH-1:0] period_out,
  output logic                 period_valid,
  output logic                 timeout,
  output logic [3:0]           edge_count
);

  typedef enum logic [1:0] {IDLE, MEASURE, TIMEOUT} state_t;

  localparam logic [CNT_WIDTH-1:0] TO_LIM = CNT_WIDTH'(TIMEOUT_CYCLES);
  localparam logic [CNT_WIDTH-1:0] ONE    = CNT_WIDTH'(1);

  state_t               state_q, state_d;
  logic                 sync1_q, sync1_d;
  logic                 sync2_q, sync2_d;
  logic                 dly_q, dly_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [CNT_WIDTH-1:0] period_q, period_d;
  logic                 valid_q, valid_d;
  logic                 timeout_q, timeout_d;
  logic [3:0]           ecnt_q, ecnt_d;
  logic                 edge_det;

  assign edge_det = sync2_q & ~dly_q;

  // cnt_q holds the number of cycles elapsed since the last detected edge,
  // so at the next edge it already equals the period and no +1 is needed.
  always_comb begin
    sync1_d   = sig_in;
    sync2_d   = sync1_q;
    dly_d     = sync2_q;
    state_d   = state_q;
    cnt_d     = cnt_q;
    period_d  = period_q;
    valid_d   = 1'b0;
    timeout_d = timeout_q;
    ecnt_d    = ecnt_q;
    if (edge_det) ecnt_d = ecnt_q + 4'd1;
    case (state_q)
      IDLE: begin
        if (edge_det) begin
          state_d = MEASURE;
          cnt_d   = ONE;
        end
      end
      MEASURE: begin
        if (edge_det) begin
          period_d = cnt_q;
          valid_d  = 1'b1;
          cnt_d    = ONE;
        end else if (cnt_q == TO_LIM) begin
          state_d   = TIMEOUT;
          timeout_d = 1'b1;
        end else begin
          cnt_d = cnt_q + ONE;
        end
      end
      TIMEOUT: begin
        if (edge_det) begin
          state_d   = MEASURE;
          timeout_d = 1'b0;
          cnt_d     = ONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst) begin
      state_q   <= IDLE;
      sync1_q   <= 1'b0;
      sync2_q   <= 1'b0;
      dly_q     <= 1'b0;
      cnt_q     <= '0;
      period_q  <= '0;
      valid_q   <= 1'b0;
      timeout_q <= 1'b0;
      ecnt_q    <= 4'd0;
    end else begin
      state_q   <= state_d;
      sync1_q   <= sync1_d;
      sync2_q   <= sync2_d;
      dly_q     <= dly_d;
      cnt_q     <= cnt_d;
      period_q  <= period_d;
      valid_q   <= valid_d;
      timeout_q <= timeout_d;
      ecnt_q    <= ecnt_d;
    end
  end

  assign period_out   = period_q;
  assign period_valid = valid_q;
  assign timeout      = timeout_q;
  assign edge_count   = ecnt_q;

endmodule

// File: tb/tb_period_meter.sv
// Scoreboard bench for period_meter: stimulus pushes expected period/edge
// count pairs, a negedge monitor pops and compares on every period_valid.
module tb_period_meter;

  localparam int W  = 8;
  localparam int TO = 200;

  logic         clk_in = 1'b0;
  logic         rst    = 1'b1;
  logic         sig_in = 1'b1;
  logic [W-1:0] period_out;
  logic         period_valid;
  logic         timeout;
  logic [3:0]   edge_count;

  typedef struct {
    logic [W-1:0] per;
    logic [3:0]   ec;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   ecm    = 0;
  logic vld_prev = 1'b0;

  period_meter #(.CNT_WIDTH(W), .TIMEOUT_CYCLES(TO)) dut (
    .clk_in      (clk_in),
    .rst         (rst),
    .sig_in      (sig_in),
    .period_out  (period_out),
    .period_valid(period_valid),
    .timeout     (timeout),
    .edge_count  (edge_count)
  );

  always #5 clk_in = ~clk_in;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic chk_zero(input string nm);
    chk({nm, "_period"},  int'(period_out),   0);
    chk({nm, "_valid"},   int'(period_valid), 0);
    chk({nm, "_timeout"}, int'(timeout),      0);
    chk({nm, "_ecnt"},    int'(edge_count),   0);
  endtask

  // One rising edge on sig_in: high for hi cycles, low for lo cycles.
  // exp_per is the hand-computed interval from the previous rise.
  task automatic rise(input int hi, input int lo, input bit exp_vld, input int exp_per);
    exp_t e;
    ecm = (ecm + 1) % 16;
    if (exp_vld) begin
      e.per = W'(exp_per);
      e.ec  = 4'(ecm);
      exp_q.push_back(e);
    end
    sig_in = 1'b1;
    repeat (hi) @(negedge clk_in);
    sig_in = 1'b0;
    repeat (lo) @(negedge clk_in);
    chk("edge_count", int'(edge_count), ecm);
  endtask

  task automatic rst_pulse();
    rst = 1'b1;
    @(negedge clk_in);
    rst = 1'b0;
    chk_zero("rst_pulse");
    ecm = 0;
    @(negedge clk_in);
    chk_zero("post_rst");
  endtask

  always @(negedge clk_in) begin
    exp_t e;
    if (period_valid) begin
      checks++;
      if (vld_prev) begin
        errors++;
        $display("FAIL valid_double: period_valid high two cycles in a row");
      end else if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_valid: period_out=%0d edge_count=%0d", period_out, edge_count);
      end else begin
        e = exp_q.pop_front();
        if (period_out !== e.per || edge_count !== e.ec) begin
          errors++;
          $display("FAIL period: got period=%0d ecnt=%0d expected period=%0d ecnt=%0d",
                   period_out, edge_count, e.per, e.ec);
        end
      end
    end
    vld_prev = period_valid;
  end

  initial begin
    // Reset held 3 cycles with sig_in toggling; sig_in low before release.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_in);
      sig_in = i[0];
      chk_zero("in_reset");
    end
    rst = 1'b0;
    @(negedge clk_in);
    chk_zero("after_release");
    repeat (3) @(negedge clk_in);

    // Period 10, then period 24
    rise(5, 5, 0, 0);
    rise(5, 5, 1, 10);
    rise(5, 5, 1, 10);
    rise(5, 5, 1, 10);
    rise(12, 12, 1, 10);
    rise(12, 12, 1, 24);
    rise(12, 12, 1, 24);
    chk("no_timeout_p24", int'(timeout), 0);

    // Edge lands exactly when the counter reaches the timeout limit
    rise(5, 195, 1, 24);
    rise(5, 5, 1, 200);
    chk("edge_at_limit_timeout", int'(timeout), 0);

    // Long low: timeout, period holds, recovery edge gives no valid
    rise(5, 250, 1, 10);
    chk("timeout_set", int'(timeout), 1);
    chk("timeout_hold_period", int'(period_out), 10);
    rise(6, 6, 0, 0);
    chk("timeout_clear", int'(timeout), 0);
    rise(6, 6, 1, 12);

    // Reset mid-period discards partial count
    rise(5, 2, 1, 12);
    rst_pulse();
    repeat (3) @(negedge clk_in);
    rise(5, 5, 0, 0);
    rise(5, 5, 1, 10);
    rise(5, 5, 1, 10);

    // 17 edges: edge_count wraps through 0 after the 16th
    rst_pulse();
    repeat (3) @(negedge clk_in);
    for (int k = 1; k <= 17; k++) begin
      rise(4, 4, k != 1, 8);
      if (k == 1)  chk("wrap_first",  int'(edge_count), 1);
      if (k == 16) chk("wrap_zero",   int'(edge_count), 0);
      if (k == 17) chk("wrap_last",   int'(edge_count), 1);
    end

    repeat (10) @(negedge clk_in);
    chk("scoreboard_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
